// File: rtl/mem_rr_arbiter_if.sv
// mem_rr_arbiter_if: requester-side and memory-side bundle of mem_rr_arbiter.
// Ports: none; the slave modport is the arbiter, the master modport is its environment.
interface mem_rr_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [N_REQ-1:0]          req_valid_i;
    logic [N_REQ-1:0]          req_ready_o;
    logic [N_REQ-1:0]          req_we_i;
    logic [N_REQ*ADDR_W-1:0]   req_addr_i;
    logic [N_REQ*DATA_W-1:0]   req_wdata_i;
    logic [N_REQ*DATA_W/8-1:0] req_wstrb_i;
    logic [N_REQ-1:0]          rsp_valid_o;
    logic [DATA_W-1:0]         rsp_rdata_o;
    logic                      rsp_err_o;
    logic                      mem_valid_o;
    logic                      mem_ready_i;
    logic                      mem_we_o;
    logic [ADDR_W-1:0]         mem_addr_o;
    logic [DATA_W-1:0]         mem_wdata_o;
    logic [DATA_W/8-1:0]       mem_wstrb_o;
    logic                      mem_rsp_valid_i;
    logic [DATA_W-1:0]         mem_rdata_i;
    logic                      mem_err_i;

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wstrb_i,
        input  mem_ready_i, mem_rsp_valid_i, mem_rdata_i, mem_err_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
    );

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wstrb_i,
        output mem_ready_i, mem_rsp_valid_i, mem_rdata_i, mem_err_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
    );
endinterface

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin share of one simple-memory port among N_REQ requesters.
// Ports: clk_i, reset_i (sync, active-high), bus (mem_rr_arbiter_if.slave).
module mem_rr_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic             clk_i,
    input  logic             reset_i,
    mem_rr_arbiter_if.slave  bus
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int SW = DATA_W / 8;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RESP} state_t;

    state_t         state;
    logic [GW-1:0]  last_grant;
    logic [GW-1:0]  grant;
    logic [TW-1:0]  timer;

    logic           win_vld;
    logic [GW-1:0]  win_idx;
    logic [N_REQ-1:0] win_oh;
    logic           to_hit;
    int             cand;

    // Search starts just past the last served requester and wraps.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = (int'(last_grant) + i) % N_REQ;
            if (!win_vld && bus.req_valid_i[GW'(cand)]) begin
                win_vld = 1'b1;
                win_idx = GW'(cand);
            end
        end
    end

    assign win_oh          = win_vld ? (N_REQ'(1) << win_idx) : '0;
    assign bus.req_ready_o = (state == IDLE) ? win_oh : '0;

    // TIMEOUT==0 leaves the timer running but never fires.
    assign to_hit = (TIMEOUT != 0) && (timer == TW'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state           <= IDLE;
            last_grant      <= GW'(N_REQ - 1);
            grant           <= '0;
            timer           <= '0;
            bus.mem_valid_o <= 1'b0;
            bus.mem_we_o    <= 1'b0;
            bus.mem_addr_o  <= '0;
            bus.mem_wdata_o <= '0;
            bus.mem_wstrb_o <= '0;
            bus.rsp_valid_o <= '0;
            bus.rsp_rdata_o <= '0;
            bus.rsp_err_o   <= 1'b0;
        end else begin
            bus.rsp_valid_o <= '0;
            unique case (state)
                IDLE: begin
                    if (win_vld) begin
                        grant           <= win_idx;
                        bus.mem_we_o    <= bus.req_we_i[win_idx];
                        bus.mem_addr_o  <= bus.req_addr_i[win_idx*ADDR_W +: ADDR_W];
                        bus.mem_wdata_o <= bus.req_wdata_i[win_idx*DATA_W +: DATA_W];
                        bus.mem_wstrb_o <= bus.req_wstrb_i[win_idx*SW +: SW];
                        bus.mem_valid_o <= 1'b1;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.mem_ready_i) begin
                        bus.mem_valid_o <= 1'b0;
                        if (bus.mem_rsp_valid_i) begin
                            bus.rsp_rdata_o <= bus.mem_rdata_i;
                            bus.rsp_err_o   <= bus.mem_err_i;
                            bus.rsp_valid_o <= N_REQ'(1) << grant;
                            state           <= RESP;
                        end else begin
                            timer <= '0;
                            state <= WAIT_RSP;
                        end
                    end
                end
                WAIT_RSP: begin
                    if (bus.mem_rsp_valid_i) begin
                        bus.rsp_rdata_o <= bus.mem_rdata_i;
                        bus.rsp_err_o   <= bus.mem_err_i;
                        bus.rsp_valid_o <= N_REQ'(1) << grant;
                        state           <= RESP;
                    end else if (to_hit) begin
                        bus.rsp_rdata_o <= '0;
                        bus.rsp_err_o   <= 1'b1;
                        bus.rsp_valid_o <= N_REQ'(1) << grant;
                        state           <= RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    last_grant <= grant;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter: directed vector bench for mem_rr_arbiter (TIMEOUT=8).
// Ports: none.
module tb_mem_rr_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    typedef struct {
        logic [3:0]  valid;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          rdy_dly;
        int          rsp_dly;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  exp_gnt;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_rr_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_rr_arbiter #(
        .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
    ) dut (
        .clk_i(clk),
        .reset_i(rst),
        .bus(bus)
    );

    int nvec = 0;
    int nbad = 0;
    vec_t tv[$];

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [3:0] valid, logic we, logic [31:0] addr,
                                logic [31:0] wdata, logic [3:0] wstrb,
                                int rdy, int rsp, logic [31:0] rdata, logic err,
                                logic [3:0] gnt, logic [31:0] erd, logic eerr);
        vec_t v;
        v.valid = valid; v.we = we; v.addr = addr; v.wdata = wdata;
        v.wstrb = wstrb; v.rdy_dly = rdy; v.rsp_dly = rsp; v.rdata = rdata;
        v.err = err; v.exp_gnt = gnt; v.exp_rdata = erd; v.exp_err = eerr;
        return v;
    endfunction

    function automatic int oh2i(logic [3:0] oh);
        for (int k = 0; k < N; k++)
            if (oh[k]) return k;
        return 0;
    endfunction

    // The expected winner g sees the vector fields exactly; every other
    // requester sees perturbed fields so a wrong mux select is visible.
    task automatic drive_reqs(vec_t v, int g);
        logic d;
        for (int k = 0; k < N; k++) begin
            d = (k != g);
            bus.req_we_i[k]             = v.we ^ d;
            bus.req_addr_i[k*AW +: AW]  = v.addr ^ (32'(k ^ g) << 12);
            bus.req_wdata_i[k*DW +: DW] = v.wdata ^ (32'(k ^ g) << 20);
            bus.req_wstrb_i[k*4 +: 4]   = v.wstrb ^ {4{d}};
        end
        bus.req_valid_i = v.valid;
    endtask

    task automatic run_vec(vec_t v);
        int g;
        int lat;
        int exp_lat;
        bit done;
        g = oh2i(v.exp_gnt);
        exp_lat = (v.rsp_dly < 0) ? TO + 1 : v.rsp_dly + 1;
        @(negedge clk);
        drive_reqs(v, g);
        bus.mem_ready_i     = 1'b0;
        bus.mem_rsp_valid_i = 1'b0;
        #1;
        chk("req_ready", 128'(bus.req_ready_o), 128'(v.exp_gnt));
        chk("rsp_pulse_len", 128'(bus.rsp_valid_o), 128'(0));
        for (int c = 0; c <= v.rdy_dly; c++) begin
            @(negedge clk);
            bus.req_valid_i[g] = 1'b0;
            bus.mem_ready_i    = (c == v.rdy_dly);
            bus.mem_rdata_i    = v.rdata;
            bus.mem_err_i      = v.err;
            bus.mem_rsp_valid_i = (c == v.rdy_dly) && (v.rsp_dly == 0);
            #1;
            chk("mem_valid", 128'(bus.mem_valid_o), 128'(1));
            chk("mem_fields",
                128'({bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_wstrb_o}),
                128'({v.we, v.addr, v.wdata, v.wstrb}));
            chk("stall_ready", 128'(bus.req_ready_o), 128'(0));
        end
        lat = 0;
        done = 1'b0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            bus.mem_ready_i     = 1'b0;
            bus.mem_rsp_valid_i = (k == v.rsp_dly);
            #1;
            if (bus.rsp_valid_o != '0) begin
                done = 1'b1;
                lat  = k;
                chk("rsp_valid", 128'(bus.rsp_valid_o), 128'(v.exp_gnt));
                chk("rsp_rdata", 128'(bus.rsp_rdata_o), 128'(v.exp_rdata));
                chk("rsp_err", 128'(bus.rsp_err_o), 128'(v.exp_err));
            end
        end
        chk("rsp_latency", 128'(lat), 128'(exp_lat));
    endtask

    task automatic run_range(int lo, int hi);
        for (int i = lo; i <= hi; i++) run_vec(tv[i]);
    endtask

    bit seen;

    initial begin
        // 0..5: all requesters valid, immediate ready and same-cycle response.
        for (int i = 0; i < 6; i++)
            tv.push_back(mk(4'hF, 1'b0, 32'h100 + 32'(i), 32'h0, 4'h0, 0, 0,
                            32'hA000_0000 + 32'(i), 1'b0,
                            4'(1 << (i % 4)), 32'hA000_0000 + 32'(i), 1'b0));
        // 6: req0 read, response one cycle after the mem handshake.
        tv.push_back(mk(4'h1, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1,
                        32'hDEADBEEF, 1'b0, 4'h1, 32'hDEADBEEF, 1'b0));
        // 7: req2 write stalled 5 cycles by mem_ready_i.
        tv.push_back(mk(4'h4, 1'b1, 32'h20, 32'h12345678, 4'h3, 5, 1,
                        32'h0, 1'b0, 4'h4, 32'h0, 1'b0));
        // 8: req1 read, no response ever: timeout error.
        tv.push_back(mk(4'h2, 1'b0, 32'h40, 32'h0, 4'h0, 0, -1,
                        32'h77777777, 1'b0, 4'h2, 32'h0, 1'b1));
        // 9: req0 read after a stray late response.
        tv.push_back(mk(4'h1, 1'b0, 32'h44, 32'h0, 4'h0, 1, 2,
                        32'h55AA55AA, 1'b0, 4'h1, 32'h55AA55AA, 1'b0));
        // 10: req1 read with slave error.
        tv.push_back(mk(4'h2, 1'b0, 32'h80, 32'h0, 4'h0, 0, 1,
                        32'hCAFEF00D, 1'b1, 4'h2, 32'hCAFEF00D, 1'b1));
        // 11: req1 and req2 valid after req1 served: req2 wins.
        tv.push_back(mk(4'h6, 1'b1, 32'h84, 32'hFFFF0000, 4'hC, 2, 3,
                        32'h0BADF00D, 1'b0, 4'h4, 32'h0BADF00D, 1'b0));
        // 12..13: after reset, req0 then req3.
        tv.push_back(mk(4'h9, 1'b0, 32'h90, 32'h0, 4'h0, 0, 1,
                        32'h11112222, 1'b0, 4'h1, 32'h11112222, 1'b0));
        tv.push_back(mk(4'h9, 1'b1, 32'h94, 32'h33334444, 4'hF, 1, 1,
                        32'h0, 1'b0, 4'h8, 32'h0, 1'b0));

        rst = 1'b1;
        bus.req_valid_i = '0;
        bus.req_we_i = '0;
        bus.req_addr_i = '0;
        bus.req_wdata_i = '0;
        bus.req_wstrb_i = '0;
        bus.mem_ready_i = 1'b0;
        bus.mem_rsp_valid_i = 1'b0;
        bus.mem_rdata_i = '0;
        bus.mem_err_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs",
            128'({bus.mem_valid_o, bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o,
                  bus.mem_we_o, bus.mem_addr_o, bus.mem_wstrb_o}),
            128'(0));
        rst = 1'b0;

        run_range(0, 8);

        // Late response after the timeout must be dropped.
        @(negedge clk);
        bus.req_valid_i     = '0;
        bus.mem_rsp_valid_i = 1'b1;
        bus.mem_rdata_i     = 32'hBAD0BAD0;
        bus.mem_err_i       = 1'b1;
        #1;
        chk("stray_rsp", 128'(bus.rsp_valid_o), 128'(0));
        @(negedge clk);
        bus.mem_rsp_valid_i = 1'b0;
        #1;
        chk("stray_rsp_next",
            128'({bus.rsp_valid_o, bus.mem_valid_o}), 128'(0));

        run_range(9, 11);

        // Reset while req3 waits for its response.
        @(negedge clk);
        drive_reqs(mk(4'h8, 1'b0, 32'hC0, 32'h0, 4'h0, 0, 0,
                      32'h0, 1'b0, 4'h8, 32'h0, 1'b0), 3);
        #1;
        chk("rst_seq_ready", 128'(bus.req_ready_o), 128'(4'h8));
        @(negedge clk);
        bus.req_valid_i = '0;
        bus.mem_ready_i = 1'b1;
        #1;
        chk("rst_seq_issue", 128'(bus.mem_valid_o), 128'(1));
        @(negedge clk);
        bus.mem_ready_i = 1'b0;
        #1;
        chk("rst_seq_wait", 128'(bus.mem_valid_o), 128'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_outs",
            128'({bus.mem_valid_o, bus.rsp_valid_o, bus.mem_addr_o,
                  bus.mem_we_o, bus.mem_wdata_o, bus.mem_wstrb_o, bus.req_ready_o}),
            128'(0));
        seen = 1'b0;
        for (int k = 0; k < TO + 6; k++) begin
            @(negedge clk);
            if (bus.rsp_valid_o != '0) seen = 1'b1;
        end
        chk("rst_no_rsp", 128'(seen), 128'(0));

        run_range(12, 13);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
